scan_responder: RTL and testbench

- Chip-side end of the scanchain link: a JTAG-style TAP that receives tck/tms/tdi from the scanchain controller and returns tdo and rtck.
- tck is treated as data. It is oversampled on the system clock, and edges are detected in the clk domain.
- Exposes an 8-bit pin register: captures i_pins into the chain, drives o_pins from the chain.
- Also provides a 16-bit IDCODE register and a 1-bit BYPASS register.

---
 rtl/scan_responder.sv | 140 ++++++++++++++
 tb/tb_scan_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_responder.sv
// ============================================================================
//  Module      : scan_responder
//  Description : Chip-side JTAG-style TAP; tck is oversampled on clk and its
//                edges drive a 16-state TAP with PINS/IDCODE/BYPASS registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_responder #(
    parameter logic [15:0] IDCODE      = 16'hA5C3,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    input  logic [7:0] i_pins,
    output logic [7:0] o_pins,
    output logic       tdo,
    output logic       rtck
);

    localparam logic [1:0] c_IR_PINS   = 2'b00;
    localparam logic [1:0] c_IR_IDCODE = 2'b01;

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
    } tap_state_t;

    logic [SYNC_STAGES-1:0] r_tck_sync;
    logic [SYNC_STAGES-1:0] r_tms_sync;
    logic [SYNC_STAGES-1:0] r_tdi_sync;
    logic                   r_tck_d;
    tap_state_t             r_state;
    logic [1:0]             r_ir;
    logic [1:0]             r_ir_sr;
    logic [15:0]            r_dr;
    logic [7:0]             r_pins;
    logic                   r_tdo;

    logic w_tck_s, w_tms_s, w_tdi_s, w_rise, w_fall;

    assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
    assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
    assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];
    assign w_rise  = w_tck_s & ~r_tck_d;
    assign w_fall  = ~w_tck_s & r_tck_d;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
        case (s)
            S_TLR:      tap_next = t ? S_TLR      : S_RTI;
            S_RTI:      tap_next = t ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   tap_next = t ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   tap_next = t ? S_EXIT1_DR : S_SHIFT_DR;
            S_SHIFT_DR: tap_next = t ? S_EXIT1_DR : S_SHIFT_DR;
            S_EXIT1_DR: tap_next = t ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: tap_next = t ? S_EXIT2_DR : S_PAUSE_DR;
            S_EXIT2_DR: tap_next = t ? S_UPD_DR   : S_SHIFT_DR;
            S_UPD_DR:   tap_next = t ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   tap_next = t ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   tap_next = t ? S_EXIT1_IR : S_SHIFT_IR;
            S_SHIFT_IR: tap_next = t ? S_EXIT1_IR : S_SHIFT_IR;
            S_EXIT1_IR: tap_next = t ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: tap_next = t ? S_EXIT2_IR : S_PAUSE_IR;
            S_EXIT2_IR: tap_next = t ? S_UPD_IR   : S_SHIFT_IR;
            S_UPD_IR:   tap_next = t ? S_SEL_DR   : S_RTI;
            default:    tap_next = S_TLR;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_d    <= 1'b0;
            r_state    <= S_TLR;
            r_ir       <= c_IR_IDCODE;
            r_ir_sr    <= 2'b00;
            r_dr       <= 16'h0000;
            r_pins     <= 8'h00;
            r_tdo      <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck};
            r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms};
            r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
            r_tck_d    <= w_tck_s;

            // Register loads/shifts are keyed on the state before the transition
            if (w_rise) begin
                case (r_state)
                    S_CAP_DR: begin
                        if (r_ir == c_IR_PINS)
                            r_dr[7:0] <= i_pins;
                        else if (r_ir == c_IR_IDCODE)
                            r_dr <= IDCODE;
                        else
                            r_dr[0] <= 1'b0;
                    end
                    S_SHIFT_DR: begin
                        if (r_ir == c_IR_PINS)
                            r_dr[7:0] <= {w_tdi_s, r_dr[7:1]};
                        else if (r_ir == c_IR_IDCODE)
                            r_dr <= {w_tdi_s, r_dr[15:1]};
                        else
                            r_dr[0] <= w_tdi_s;
                    end
                    S_CAP_IR:   r_ir_sr <= 2'b01;
                    S_SHIFT_IR: r_ir_sr <= {w_tdi_s, r_ir_sr[1]};
                    default: ;
                endcase
                r_state <= tap_next(r_state, w_tms_s);
            end

            if (w_fall) begin
                case (r_state)
                    S_SHIFT_DR: r_tdo <= r_dr[0];
                    S_SHIFT_IR: r_tdo <= r_ir_sr[0];
                    default:    r_tdo <= 1'b0;
                endcase
                case (r_state)
                    S_UPD_DR: if (r_ir == c_IR_PINS) r_pins <= r_dr[7:0];
                    S_UPD_IR: r_ir <= r_ir_sr;
                    S_TLR:    r_ir <= c_IR_IDCODE;
                    default: ;
                endcase
            end
        end
    end

    assign o_pins = r_pins;
    assign tdo    = r_tdo;
    assign rtck   = r_tck_d;

endmodule

`default_nettype wire

// File: tb/tb_scan_responder.sv
// ============================================================================
//  Module      : tb_scan_responder
//  Description : Self-checking bench for scan_responder against a tck-level
//                behavioural TAP model, plus directed literal scans.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_responder;

    logic       clk = 1'b0;
    logic       reset, tck, tms, tdi;
    logic [7:0] i_pins, o_pins;
    logic       tdo, rtck;

    always #5 clk = ~clk;

    scan_responder #(.IDCODE(16'hA5C3), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .tck(tck), .tms(tms), .tdi(tdi),
        .i_pins(i_pins), .o_pins(o_pins), .tdo(tdo), .rtck(rtck)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    int unsigned cyc      = 0;
    int unsigned last_chg = 0;
    bit          chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural TAP model (one step per tck edge) ----------
    localparam int M_TLR = 0,  M_RTI = 1,  M_SDS = 2,  M_CDR = 3,  M_SDR = 4,  M_E1D = 5,
                   M_PDR = 6,  M_E2D = 7,  M_UDR = 8,  M_SIS = 9,  M_CIR = 10, M_SIR = 11,
                   M_E1I = 12, M_PIR = 13, M_E2I = 14, M_UIR = 15;

    int          m_st;
    logic [1:0]  m_ir, m_irsr;
    logic [15:0] m_dr;
    logic [7:0]  m_pins;
    logic        m_tdo, m_tck;

    function automatic int nxt(input int s, input logic t);
        case (s)
            M_TLR: return t ? M_TLR : M_RTI;
            M_RTI: return t ? M_SDS : M_RTI;
            M_SDS: return t ? M_SIS : M_CDR;
            M_CDR: return t ? M_E1D : M_SDR;
            M_SDR: return t ? M_E1D : M_SDR;
            M_E1D: return t ? M_UDR : M_PDR;
            M_PDR: return t ? M_E2D : M_PDR;
            M_E2D: return t ? M_UDR : M_SDR;
            M_UDR: return t ? M_SDS : M_RTI;
            M_SIS: return t ? M_TLR : M_CIR;
            M_CIR: return t ? M_E1I : M_SIR;
            M_SIR: return t ? M_E1I : M_SIR;
            M_E1I: return t ? M_UIR : M_PIR;
            M_PIR: return t ? M_E2I : M_PIR;
            M_E2I: return t ? M_UIR : M_SIR;
            default: return t ? M_SDS : M_RTI;
        endcase
    endfunction

    task automatic m_rise(input logic t, input logic d, input logic [7:0] pins);
        int unsigned len, mask, low;
        if (m_st == M_CDR) begin
            if (m_ir == 2'd0)      m_dr[7:0] = pins;
            else if (m_ir == 2'd1) m_dr = 16'hA5C3;
            else                   m_dr[0] = 1'b0;
        end else if (m_st == M_SDR) begin
            len  = (m_ir == 2'd0) ? 8 : (m_ir == 2'd1) ? 16 : 1;
            mask = (1 << len) - 1;
            low  = ((32'(m_dr) & mask) >> 1) | (32'(d) << (len - 1));
            m_dr = 16'((32'(m_dr) & ~mask) | low);
        end else if (m_st == M_CIR) begin
            m_irsr = 2'd1;
        end else if (m_st == M_SIR) begin
            m_irsr = 2'((m_irsr >> 1) | (2'(d) << 1));
        end
        m_st = nxt(m_st, t);
    endtask

    task automatic m_fall();
        m_tdo = (m_st == M_SDR) ? m_dr[0] : (m_st == M_SIR) ? m_irsr[0] : 1'b0;
        if (m_st == M_UDR && m_ir == 2'd0) m_pins = m_dr[7:0];
        if (m_st == M_UIR) m_ir = m_irsr;
        if (m_st == M_TLR) m_ir = 2'd1;
    endtask

    task automatic m_reset();
        m_st = M_TLR; m_ir = 2'd1; m_irsr = 2'd0; m_dr = 16'h0;
        m_pins = 8'h00; m_tdo = 1'b0; m_tck = 1'b0;
    endtask

    // Continuous comparison once the last tck change has fully propagated
    always @(negedge clk) begin
        if (chk_en && !reset && (cyc - last_chg) >= 4) begin
            check("tdo",    32'(tdo),    32'(m_tdo));
            check("o_pins", 32'(o_pins), 32'(m_pins));
            check("rtck",   32'(rtck),   32'(m_tck));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic half(input logic v, input int n);
        @(posedge clk); #1;
        tck = v; m_tck = v;
        if (v) m_rise(tms, tdi, i_pins); else m_fall();
        last_chg = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic d, output logic o);
        tms = t; tdi = d;
        half(1'b1, $urandom_range(4, 7));
        half(1'b0, $urandom_range(4, 7));
        o = tdo;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; tck = 1'b1;
        m_reset();
        @(posedge clk); #1 tck = 1'b0;
        @(posedge clk); #1 tck = 1'b1;
        @(posedge clk); #1;
        check("reset_o_pins", 32'(o_pins), 32'h00);
        check("reset_tdo",    32'(tdo),    32'h0);
        check("reset_rtck",   32'(rtck),   32'h0);
        tck = 1'b0; reset = 1'b0; last_chg = cyc;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic shift_ir(input logic [1:0] v);
        logic o;
        pulse(1, 0, o); pulse(1, 0, o); pulse(0, 0, o); pulse(0, 0, o);
        pulse(0, v[0], o); pulse(1, v[1], o);
        pulse(1, 0, o); pulse(0, 0, o);
    endtask

    task automatic shift_dr(input logic [15:0] d, input int len, output logic [15:0] out);
        logic o;
        out = 16'h0;
        pulse(1, 0, o); pulse(0, 0, o); pulse(0, 0, o);
        out[0] = o;
        for (int i = 0; i < len; i++) begin
            pulse(i == len - 1, d[i], o);
            if (i < len - 1) out[i+1] = o;
        end
        pulse(1, 0, o); pulse(0, 0, o);
    endtask

    initial begin
        logic [15:0] r;
        logic        o;
        reset = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; i_pins = 8'h00;
        m_reset();
        chk_en = 1'b1;
        do_reset();

        // IDCODE selected after reset
        pulse(0, 0, o);
        shift_dr(16'h0000, 16, r);
        check("idcode_scan", 32'(r), 32'hA5C3);

        // PINS capture/update
        shift_ir(2'b00);
        i_pins = 8'h3C;
        shift_dr(16'h005A, 8, r);
        check("pins_tdo", 32'(r[7:0]), 32'h3C);
        check("pins_update", 32'(o_pins), 32'h5A);

        // BYPASS: one-tck delay, first bit 0
        shift_ir(2'b11);
        shift_dr(16'h000D, 4, r);
        check("bypass_tdo", 32'(r[3:0]), 32'hA);
        check("bypass_pins_hold", 32'(o_pins), 32'h5A);

        // Five tms=1 pulses from Shift-DR reach Test-Logic-Reset
        pulse(1, 0, o); pulse(0, 0, o); pulse(0, 0, o);
        repeat (5) pulse(1, 0, o);
        pulse(0, 0, o);
        shift_dr(16'h0000, 16, r);
        check("tlr_idcode_scan", 32'(r), 32'hA5C3);

        // rtck latency: SYNC_STAGES+1 = 3 clk
        tms = 1'b0;
        @(posedge clk); #1;
        tck = 1'b1; m_tck = 1'b1; m_rise(tms, tdi, i_pins); last_chg = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rtck_before_3", 32'(rtck), 32'h0);
        @(posedge clk); #1;
        check("rtck_at_3", 32'(rtck), 32'h1);
        half(1'b0, 5);

        // Reset in the middle of a PINS shift
        shift_ir(2'b00);
        i_pins = 8'hC3;
        pulse(1, 0, o); pulse(0, 0, o); pulse(0, 0, o);
        for (int i = 0; i < 4; i++) pulse(0, 1, o);
        do_reset();
        check("midreset_o_pins", 32'(o_pins), 32'h00);
        pulse(1, 0, o);
        pulse(0, 0, o);
        shift_dr(16'h0000, 16, r);
        check("midreset_idcode", 32'(r), 32'hA5C3);

        // Randomised traffic against the model
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                i_pins = 8'($urandom);
                pulse($urandom_range(0, 2) == 0, 1'($urandom), o);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
